// File: rtl/id_ex_stage.sv
// Decode/operand stage and ID/EX pipeline register: field decode, WB bypass,
// load-use stall with bubble insertion, branch flush and a saturating stall counter.
module id_ex_stage #(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 5,
   parameter bit BYPASS_EN = 1'b1,
   parameter int CNT_W     = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              id_valid,
   input  logic [DATA_W-1:0] id_instr,
   input  logic [DATA_W-1:0] id_pc4,
   output logic              id_ready,
   output logic [ADDR_W-1:0] RdReg1,
   output logic [ADDR_W-1:0] RdReg2,
   input  logic [DATA_W-1:0] RdData1,
   input  logic [DATA_W-1:0] RdData2,
   input  logic              wb_RegWr,
   input  logic [ADDR_W-1:0] wb_WrReg,
   input  logic [DATA_W-1:0] wb_WrData,
   input  logic              flush,
   output logic              ex_valid,
   output logic [DATA_W-1:0] ex_rs_data,
   output logic [DATA_W-1:0] ex_rt_data,
   output logic [DATA_W-1:0] ex_imm,
   output logic [DATA_W-1:0] ex_pc4,
   output logic [ADDR_W-1:0] ex_dest,
   output logic              ex_RegWr,
   output logic              ex_mem_read,
   output logic              ex_mem_write,
   output logic              ex_branch,
   output logic              ex_alu_src,
   output logic [5:0]        ex_funct,
   output logic              ex_illegal,
   output logic [CNT_W-1:0]  stall_cnt
);

   localparam logic [5:0]        OP_RTYPE = 6'h00;
   localparam logic [5:0]        OP_ADDI  = 6'h08;
   localparam logic [5:0]        OP_LW    = 6'h23;
   localparam logic [5:0]        OP_SW    = 6'h2B;
   localparam logic [5:0]        OP_BEQ   = 6'h04;
   localparam logic [5:0]        FN_ADD   = 6'h20;
   localparam logic [ADDR_W-1:0] REG_ZERO = {ADDR_W{1'b0}};
   localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [5:0]        opcode;
   logic [ADDR_W-1:0] rsAddr;
   logic [ADDR_W-1:0] rtAddr;
   logic [ADDR_W-1:0] rdAddr;
   logic              isRtype;
   logic              isAddi;
   logic              isLw;
   logic              isSw;
   logic              isBeq;
   logic              isLegal;
   logic              usesRt;
   logic [ADDR_W-1:0] destReg;
   logic              regWr;
   logic [DATA_W-1:0] immExt;
   logic [DATA_W-1:0] opA;
   logic [DATA_W-1:0] opB;
   logic              hazard;
   logic              stall;
   logic              loadInstr;
   logic              unusedShamt;

   // Selects the WB write data when it targets a nonzero register being read this cycle.
   function automatic logic [DATA_W-1:0] bypass(
      input logic [ADDR_W-1:0] rdAddrIn,
      input logic [DATA_W-1:0] rdDataIn,
      input logic              wrEn,
      input logic [ADDR_W-1:0] wrAddr,
      input logic [DATA_W-1:0] wrData
   );
      if (BYPASS_EN && wrEn && (wrAddr != REG_ZERO) && (wrAddr == rdAddrIn)) begin
         return wrData;
      end else begin
         return rdDataIn;
      end
   endfunction

   assign opcode      = id_instr[31:26];
   assign rsAddr      = id_instr[25:21];
   assign rtAddr      = id_instr[20:16];
   assign rdAddr      = id_instr[15:11];
   assign unusedShamt = ^id_instr[10:6];
   assign RdReg1      = rsAddr;
   assign RdReg2      = rtAddr;
   assign immExt      = {{(DATA_W-16){id_instr[15]}}, id_instr[15:0]};

   // Opcode decode into one-hot instruction classes.
   always_comb begin
      isRtype = 1'b0;
      isAddi  = 1'b0;
      isLw    = 1'b0;
      isSw    = 1'b0;
      isBeq   = 1'b0;
      case (opcode)
         OP_RTYPE: isRtype = 1'b1;
         OP_ADDI:  isAddi  = 1'b1;
         OP_LW:    isLw    = 1'b1;
         OP_SW:    isSw    = 1'b1;
         OP_BEQ:   isBeq   = 1'b1;
         default:  isRtype = 1'b0;
      endcase
   end

   assign isLegal = isRtype | isAddi | isLw | isSw | isBeq;
   assign usesRt  = isRtype | isSw | isBeq;

   // Destination register; anything that does not write back gets $0.
   always_comb begin
      destReg = REG_ZERO;
      if (isRtype) begin
         destReg = rdAddr;
      end else if (isAddi || isLw) begin
         destReg = rtAddr;
      end else begin
         destReg = REG_ZERO;
      end
   end

   assign regWr = (isRtype | isAddi | isLw) & (destReg != REG_ZERO);
   assign opA   = bypass(rsAddr, RdData1, wb_RegWr, wb_WrReg, wb_WrData);
   assign opB   = bypass(rtAddr, RdData2, wb_RegWr, wb_WrReg, wb_WrData);

   assign hazard = id_valid & ex_valid & ex_mem_read & (ex_dest != REG_ZERO) &
                   ((ex_dest == rsAddr) | ((ex_dest == rtAddr) & usesRt));
   // Flush kills the ID instruction outright, so a coincident hazard is moot.
   assign stall     = hazard & ~flush;
   assign loadInstr = id_valid & ~flush & ~stall & isLegal;
   assign id_ready  = ~stall;

   // ID/EX pipeline register: capture the decoded instruction or load a bubble.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ex_valid     <= 1'b0;
         ex_rs_data   <= {DATA_W{1'b0}};
         ex_rt_data   <= {DATA_W{1'b0}};
         ex_imm       <= {DATA_W{1'b0}};
         ex_pc4       <= {DATA_W{1'b0}};
         ex_dest      <= REG_ZERO;
         ex_RegWr     <= 1'b0;
         ex_mem_read  <= 1'b0;
         ex_mem_write <= 1'b0;
         ex_branch    <= 1'b0;
         ex_alu_src   <= 1'b0;
         ex_funct     <= 6'h00;
      end else if (loadInstr) begin
         ex_valid     <= 1'b1;
         ex_rs_data   <= opA;
         ex_rt_data   <= opB;
         ex_imm       <= immExt;
         ex_pc4       <= id_pc4;
         ex_dest      <= destReg;
         ex_RegWr     <= regWr;
         ex_mem_read  <= isLw;
         ex_mem_write <= isSw;
         ex_branch    <= isBeq;
         ex_alu_src   <= isAddi | isLw | isSw;
         ex_funct     <= isRtype ? id_instr[5:0] : FN_ADD;
      end else begin
         ex_valid     <= 1'b0;
         ex_rs_data   <= {DATA_W{1'b0}};
         ex_rt_data   <= {DATA_W{1'b0}};
         ex_imm       <= {DATA_W{1'b0}};
         ex_pc4       <= {DATA_W{1'b0}};
         ex_dest      <= REG_ZERO;
         ex_RegWr     <= 1'b0;
         ex_mem_read  <= 1'b0;
         ex_mem_write <= 1'b0;
         ex_branch    <= 1'b0;
         ex_alu_src   <= 1'b0;
         ex_funct     <= 6'h00;
      end
   end

   // Sticky flag for an unsupported opcode reaching decode.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ex_illegal <= 1'b0;
      end else if (id_valid && !flush && !isLegal) begin
         ex_illegal <= 1'b1;
      end else begin
         ex_illegal <= ex_illegal;
      end
   end

   // Saturating count of load-use stall cycles.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cnt <= {CNT_W{1'b0}};
      end else if (stall && (stall_cnt != CNT_MAX)) begin
         stall_cnt <= stall_cnt + CNT_ONE;
      end else begin
         stall_cnt <= stall_cnt;
      end
   end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios plus randomized traffic, all checked
// against a transaction-level model of the ID/EX register, hazard rule and counter.
module tb_id_ex_stage;
   localparam int CW = 3;

   logic          clk = 1'b0;
   logic          reset;
   logic          id_valid;
   logic [31:0]   id_instr;
   logic [31:0]   id_pc4;
   logic          id_ready;
   logic [4:0]    RdReg1;
   logic [4:0]    RdReg2;
   logic [31:0]   RdData1;
   logic [31:0]   RdData2;
   logic          wb_RegWr;
   logic [4:0]    wb_WrReg;
   logic [31:0]   wb_WrData;
   logic          flush;
   logic          ex_valid;
   logic [31:0]   ex_rs_data;
   logic [31:0]   ex_rt_data;
   logic [31:0]   ex_imm;
   logic [31:0]   ex_pc4;
   logic [4:0]    ex_dest;
   logic          ex_RegWr;
   logic          ex_mem_read;
   logic          ex_mem_write;
   logic          ex_branch;
   logic          ex_alu_src;
   logic [5:0]    ex_funct;
   logic          ex_illegal;
   logic [CW-1:0] stall_cnt;

   int errors = 0;
   int checks = 0;

   // model state: what the ID/EX register and counters should hold
   logic        mValid, mRegWr, mMemRead, mMemWrite, mBranch, mAluSrc, mIllegal;
   logic [31:0] mRs, mRt, mImm, mPc4;
   logic [4:0]  mDest;
   logic [5:0]  mFunct;
   int          mCnt;
   logic        lastStall;

   always #5 clk = ~clk;

   id_ex_stage #(.DATA_W(32), .ADDR_W(5), .BYPASS_EN(1'b1), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_instr(id_instr), .id_pc4(id_pc4),
      .id_ready(id_ready), .RdReg1(RdReg1), .RdReg2(RdReg2), .RdData1(RdData1), .RdData2(RdData2),
      .wb_RegWr(wb_RegWr), .wb_WrReg(wb_WrReg), .wb_WrData(wb_WrData), .flush(flush),
      .ex_valid(ex_valid), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
      .ex_pc4(ex_pc4), .ex_dest(ex_dest), .ex_RegWr(ex_RegWr), .ex_mem_read(ex_mem_read),
      .ex_mem_write(ex_mem_write), .ex_branch(ex_branch), .ex_alu_src(ex_alu_src),
      .ex_funct(ex_funct), .ex_illegal(ex_illegal), .stall_cnt(stall_cnt)
   );

   function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input logic [5:0] fn);
      logic [4:0] a, b, c;
      a = 5'(rs); b = 5'(rt); c = 5'(rd);
      return {6'h00, a, b, c, 5'h00, fn};
   endfunction

   function automatic logic [31:0] itype(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
      logic [4:0] a, b;
      a = 5'(rs); b = 5'(rt);
      return {op, a, b, imm};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic modelReset();
      mValid = 1'b0; mRegWr = 1'b0; mMemRead = 1'b0; mMemWrite = 1'b0; mBranch = 1'b0;
      mAluSrc = 1'b0; mIllegal = 1'b0; mRs = 32'd0; mRt = 32'd0; mImm = 32'd0; mPc4 = 32'd0;
      mDest = 5'd0; mFunct = 6'd0; mCnt = 0; lastStall = 1'b0;
   endtask

   task automatic compareAll(input string tag);
      chk({tag, ".valid"}, {31'd0, ex_valid}, {31'd0, mValid});
      chk({tag, ".rs"}, ex_rs_data, mRs);
      chk({tag, ".rt"}, ex_rt_data, mRt);
      chk({tag, ".imm"}, ex_imm, mImm);
      chk({tag, ".pc4"}, ex_pc4, mPc4);
      chk({tag, ".dest"}, {27'd0, ex_dest}, {27'd0, mDest});
      chk({tag, ".ctl"}, {27'd0, ex_RegWr, ex_mem_read, ex_mem_write, ex_branch, ex_alu_src},
          {27'd0, mRegWr, mMemRead, mMemWrite, mBranch, mAluSrc});
      chk({tag, ".funct"}, {26'd0, ex_funct}, {26'd0, mFunct});
      chk({tag, ".illegal"}, {31'd0, ex_illegal}, {31'd0, mIllegal});
      chk({tag, ".stallcnt"}, {29'd0, stall_cnt}, 32'(mCnt));
   endtask

   // One clock with the currently driven inputs: check id_ready, advance model, check EX.
   task automatic cycle(input string tag);
      logic [5:0]  op;
      logic [4:0]  rs, rt, d;
      logic        lg, ur, w, mr, mw, br, as, hz, st, take;
      logic [5:0]  fn;
      logic [31:0] a, b;
      #1;
      op = id_instr[31:26]; rs = id_instr[25:21]; rt = id_instr[20:16];
      lg = 1'b1; ur = 1'b0; w = 1'b0; mr = 1'b0; mw = 1'b0; br = 1'b0; as = 1'b0;
      d = 5'd0; fn = 6'h20;
      case (op)
         6'h00: begin ur = 1'b1; w = 1'b1; d = id_instr[15:11]; fn = id_instr[5:0]; end
         6'h08: begin w = 1'b1; d = rt; as = 1'b1; end
         6'h23: begin w = 1'b1; d = rt; mr = 1'b1; as = 1'b1; end
         6'h2B: begin ur = 1'b1; mw = 1'b1; as = 1'b1; end
         6'h04: begin ur = 1'b1; br = 1'b1; end
         default: lg = 1'b0;
      endcase
      hz = id_valid && mValid && mMemRead && (mDest != 5'd0) && ((mDest == rs) || ((mDest == rt) && ur));
      st = hz && !flush;
      chk({tag, ".ready"}, {31'd0, id_ready}, {31'd0, !st});
      a = (wb_RegWr && wb_WrReg != 5'd0 && wb_WrReg == rs) ? wb_WrData : RdData1;
      b = (wb_RegWr && wb_WrReg != 5'd0 && wb_WrReg == rt) ? wb_WrData : RdData2;
      take = id_valid && !flush && !st && lg;
      @(posedge clk);
      if (id_valid && !flush && !lg) mIllegal = 1'b1;
      if (st && mCnt < (2**CW - 1)) mCnt = mCnt + 1;
      lastStall = st;
      mValid = take;
      mRs = take ? a : 32'd0;
      mRt = take ? b : 32'd0;
      mImm = take ? 32'($signed(id_instr[15:0])) : 32'd0;
      mPc4 = take ? id_pc4 : 32'd0;
      mDest = take ? d : 5'd0;
      mRegWr = take && w && (d != 5'd0);
      mMemRead = take && mr;
      mMemWrite = take && mw;
      mBranch = take && br;
      mAluSrc = take && as;
      mFunct = take ? fn : 6'h00;
      #1;
      compareAll(tag);
   endtask

   task automatic drive(input logic [31:0] instr, input logic [31:0] pc4, input logic [31:0] d1, input logic [31:0] d2);
      id_valid = 1'b1; id_instr = instr; id_pc4 = pc4; RdData1 = d1; RdData2 = d2;
   endtask

   initial begin
      logic [5:0] ops [7];
      ops[0] = 6'h00; ops[1] = 6'h08; ops[2] = 6'h23; ops[3] = 6'h2B;
      ops[4] = 6'h04; ops[5] = 6'h3F; ops[6] = 6'h01;
      modelReset();
      reset = 1'b0; flush = 1'b0; wb_RegWr = 1'b0; wb_WrReg = 5'd0; wb_WrData = 32'd0;
      drive(itype(6'h08, 1, 3, 16'hFFFB), 32'h0000_0104, 32'd100, 32'd0);

      // 1: reset held while clocking a valid addi
      repeat (3) @(posedge clk);
      #1;
      compareAll("reset");
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("reset.ready", {31'd0, id_ready}, 32'd1);

      // 2: addi $3,$1,-5
      cycle("addi");
      chk("addi.rs100", ex_rs_data, 32'd100);
      chk("addi.imm", ex_imm, 32'hFFFF_FFFB);
      chk("addi.dest3", {27'd0, ex_dest}, 32'd3);
      chk("addi.regwr", {31'd0, ex_RegWr}, 32'd1);

      // 3: bypass of a same-cycle WB write, and $0 never bypassed
      drive(rtype(2, 2, 4, 6'h20), 32'h0000_0108, 32'd7, 32'd7);
      wb_RegWr = 1'b1; wb_WrReg = 5'd2; wb_WrData = 32'd9;
      cycle("byp");
      chk("byp.rs9", ex_rs_data, 32'd9);
      chk("byp.rt9", ex_rt_data, 32'd9);
      wb_WrReg = 5'd0;
      cycle("byp0");
      chk("byp0.rs7", ex_rs_data, 32'd7);
      chk("byp0.rt7", ex_rt_data, 32'd7);
      wb_RegWr = 1'b0;

      // 4: lw $5,0($1) followed by dependent add $6,$5,$0
      drive(itype(6'h23, 1, 5, 16'h0000), 32'h0000_010C, 32'h40, 32'd0);
      cycle("lw");
      drive(rtype(5, 0, 6, 6'h20), 32'h0000_0110, 32'd11, 32'd0);
      cycle("luse");
      chk("luse.bubble", {31'd0, ex_valid}, 32'd0);
      chk("luse.cnt1", {29'd0, stall_cnt}, 32'd1);
      cycle("luse.issue");
      chk("luse.issued", {27'd0, ex_valid, ex_dest}, {27'd0, 1'b1, 5'd6});

      // 5: hazard coincident with flush, then an unsupported opcode
      drive(itype(6'h23, 1, 5, 16'h0004), 32'h0000_0114, 32'h40, 32'd0);
      cycle("lw2");
      drive(rtype(5, 0, 6, 6'h20), 32'h0000_0118, 32'd11, 32'd0);
      flush = 1'b1;
      cycle("flush");
      chk("flush.cnt", {29'd0, stall_cnt}, 32'd1);
      flush = 1'b0;
      drive({6'h3F, 26'h0}, 32'h0000_011C, 32'd0, 32'd0);
      cycle("illegal");
      chk("illegal.flag", {31'd0, ex_illegal, ex_valid}, 32'd2);

      // reset asserted in the middle of a stall cycle
      drive(itype(6'h23, 2, 1, 16'h0000), 32'h0000_0120, 32'd0, 32'd0);
      cycle("lw3");
      drive(rtype(1, 1, 3, 6'h22), 32'h0000_0124, 32'd5, 32'd5);
      #2;
      chk("midrst.stall", {31'd0, id_ready}, 32'd0);
      reset = 1'b0;
      #1;
      modelReset();
      compareAll("midrst");
      chk("midrst.ready", {31'd0, id_ready}, 32'd1);
      @(negedge clk);
      reset = 1'b1;
      cycle("postrst");

      // stall counter saturation
      for (int i = 0; i < 8; i++) begin
         drive(itype(6'h23, 2, 1, 16'h0000), 32'h0000_0200, 32'd0, 32'd0);
         cycle("sat.lw");
         drive(rtype(1, 1, 3, 6'h20), 32'h0000_0204, 32'd1, 32'd1);
         cycle("sat.stall");
         cycle("sat.issue");
      end
      chk("sat.max", {29'd0, stall_cnt}, 32'd7);

      // randomized traffic; upstream holds the instruction while stalled
      for (int n = 0; n < 400; n++) begin
         if (!lastStall) begin
            id_valid = ($urandom_range(0, 9) != 0);
            id_instr = {ops[$urandom_range(0, 6)], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                        5'($urandom_range(0, 3)), 11'($urandom)};
            id_pc4 = $urandom;
         end
         RdData1 = $urandom; RdData2 = $urandom;
         wb_RegWr = $urandom_range(0, 1); wb_WrReg = 5'($urandom_range(0, 3)); wb_WrData = $urandom;
         flush = ($urandom_range(0, 9) == 0);
         cycle("rand");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
